wb_cmd_master: RTL and testbench

Wishbone bus master that sits directly downstream of the CPU controller's memory-access port. It accepts 34-bit command words (set address, write, read) over a strobe/busy handshake, runs one classic Wishbone bus cycle per access with a timeout, and returns exactly one 34-bit response word per accepted command. It holds an auto-incrementing address register so that sequential accesses need only one set-address command.

---
 rtl/wb_cmd_master.sv | 135 +++++++++++++
 tb/tb_wb_cmd_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic master driven by 34-bit command words; returns one response
// word per accepted command and keeps an auto-incrementing address register.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ADDR_INC       = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_stb,
  input  logic [33:0] cmd_word,
  output logic        cmd_busy,
  output logic        rsp_stb,
  output logic [33:0] rsp_word,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic [31:0] wb_dat_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] OP_SET_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;

  localparam logic [1:0] RSP_ADDR_ACK  = 2'b00;
  localparam logic [1:0] RSP_READ_DATA = 2'b01;
  localparam logic [1:0] RSP_WRITE_ACK = 2'b10;
  localparam logic [1:0] RSP_ERROR     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_addr;
  logic [31:0]       r_dat_o;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic [33:0]       r_rsp_word;

  logic              w_accept;
  logic              w_timeout;
  logic [1:0]        w_opcode;
  logic [31:0]       w_payload;

  assign w_opcode  = cmd_word[33:32];
  assign w_payload = cmd_word[31:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        w_next = S_IDLE;
        if (cmd_stb) begin
          w_accept = 1'b1;
          w_next   = (w_opcode == OP_WRITE || w_opcode == OP_READ) ? S_BUS : S_RESP;
        end
      end
      S_BUS: begin
        w_timeout = !wb_ack && !wb_err && (r_cnt == CNT_LAST);
        if (wb_ack || wb_err || w_timeout) w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_dat_o    <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_rsp_word <= '0;
    end else begin
      if (w_accept) begin
        unique case (w_opcode)
          OP_SET_ADDR: begin
            r_addr     <= w_payload;
            r_rsp_word <= {RSP_ADDR_ACK, w_payload};
          end
          OP_WRITE, OP_READ: begin
            r_we    <= (w_opcode == OP_WRITE);
            r_dat_o <= w_payload;
            r_cnt   <= '0;
          end
          default: r_rsp_word <= {RSP_ERROR, r_addr};
        endcase
      end
      if (r_state == S_BUS) begin
        // Error takes priority over a simultaneous acknowledge.
        if (wb_err || w_timeout) begin
          r_rsp_word <= {RSP_ERROR, r_addr};
        end else if (wb_ack) begin
          r_rsp_word <= r_we ? {RSP_WRITE_ACK, r_addr} : {RSP_READ_DATA, wb_dat_i};
          r_addr     <= r_addr + ADDR_INC;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign cmd_busy = (r_state == S_BUS);
  assign rsp_stb  = (r_state == S_RESP);
  assign rsp_word = r_rsp_word;
  assign wb_cyc   = (r_state == S_BUS);
  assign wb_stb   = (r_state == S_BUS);
  assign wb_we    = r_we;
  assign wb_adr   = r_addr;
  assign wb_dat_o = r_dat_o;
  assign wb_sel   = (r_state == S_BUS) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed, table-driven bench for wb_cmd_master with TIMEOUT_CYCLES = 8.
module tb_wb_cmd_master;

  localparam logic [1:0] OP_SET = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RSV = 2'b11;
  localparam logic [1:0] R_ADDR = 2'b00, R_RD = 2'b01, R_WR = 2'b10, R_ERR = 2'b11;
  localparam int M_ACK = 0, M_ACKERR = 1, M_NONE = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy, rsp_stb;
  logic [33:0] rsp_word;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic [31:0] wb_dat_i;

  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8), .ADDR_INC(32'd4)) dut (
    .clk(clk), .reset(reset),
    .cmd_stb(cmd_stb), .cmd_word(cmd_word), .cmd_busy(cmd_busy),
    .rsp_stb(rsp_stb), .rsp_word(rsp_word),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_stb) rsp_count++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] payload;
    int          waits;
    int          mode;
    logic [31:0] rdata;
    logic [1:0]  exp_code;
    logic [31:0] exp_pay;
    int          exp_lat;
    int          exp_stb;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[11];

  // Issue one command at an idle point, play the slave, and report what came back.
  task automatic run_cmd(input vec_t v, output logic [33:0] word, output int lat,
                         output int stb_cnt, output logic [31:0] bus_adr,
                         output logic bus_we, output logic [31:0] bus_dat,
                         output logic [3:0] bus_sel, output logic busy_ok);
    bit got = 0;
    word = '0; lat = 0; stb_cnt = 0; bus_adr = '0; bus_we = 0; bus_dat = '0;
    bus_sel = '0; busy_ok = 1;
    cmd_stb  = 1'b1;
    cmd_word = {v.op, v.payload};
    tick();
    cmd_stb  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (wb_stb) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          bus_adr = wb_adr; bus_we = wb_we; bus_dat = wb_dat_o; bus_sel = wb_sel;
        end
        if (!cmd_busy || !wb_cyc) busy_ok = 0;
        if (v.mode != M_NONE && stb_cnt == v.waits + 1) begin
          wb_ack   = (v.mode != M_ERR);
          wb_err   = (v.mode == M_ACKERR || v.mode == M_ERR);
          wb_dat_i = v.rdata;
        end
      end
      if (rsp_stb) begin
        if (cmd_busy) busy_ok = 0;
        word = rsp_word;
        lat  = c;
        got  = 1;
        break;
      end
      tick();
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (!got) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [33:0] word;
    int          lat, stb_cnt, base;
    logic [31:0] bus_adr, bus_dat, prev_addr;
    logic        bus_we, busy_ok;
    logic [3:0]  bus_sel;

    //          op      payload       waits mode      rdata         code    pay           lat stb addr
    vecs[0]  = '{OP_SET, 32'h00001000, 0, M_ACK,    32'h0,        R_ADDR, 32'h00001000, 1, 0, 32'h00001000};
    vecs[1]  = '{OP_WR,  32'hDEADBEEF, 0, M_ACK,    32'h0,        R_WR,   32'h00001000, 2, 1, 32'h00001004};
    vecs[2]  = '{OP_RD,  32'h0,        3, M_ACK,    32'h12345678, R_RD,   32'h12345678, 5, 4, 32'h00001008};
    vecs[3]  = '{OP_SET, 32'h00002000, 0, M_ACK,    32'h0,        R_ADDR, 32'h00002000, 1, 0, 32'h00002000};
    vecs[4]  = '{OP_RD,  32'h0,        0, M_ACKERR, 32'hCAFEF00D, R_ERR,  32'h00002000, 2, 1, 32'h00002000};
    vecs[5]  = '{OP_RD,  32'h0,        0, M_NONE,   32'h0,        R_ERR,  32'h00002000, 9, 8, 32'h00002000};
    vecs[6]  = '{OP_SET, 32'h00003000, 0, M_ACK,    32'h0,        R_ADDR, 32'h00003000, 1, 0, 32'h00003000};
    vecs[7]  = '{OP_SET, 32'hFFFFFFFC, 0, M_ACK,    32'h0,        R_ADDR, 32'hFFFFFFFC, 1, 0, 32'hFFFFFFFC};
    vecs[8]  = '{OP_WR,  32'h00000055, 1, M_ACK,    32'h0,        R_WR,   32'hFFFFFFFC, 3, 2, 32'h00000000};
    vecs[9]  = '{OP_RSV, 32'h0000ABCD, 0, M_ACK,    32'h0,        R_ERR,  32'h00000000, 1, 0, 32'h00000000};
    vecs[10] = '{OP_WR,  32'h0000AAAA, 2, M_ERR,    32'h0,        R_ERR,  32'h00000000, 4, 3, 32'h00000000};

    reset = 1'b1; cmd_stb = 1'b0; cmd_word = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_ctrl", {60'd0, cmd_busy, rsp_stb, wb_cyc, wb_stb}, 64'd0);
    check("rst_we_sel", {59'd0, wb_we, wb_sel}, 64'd0);
    check("rst_rsp_word", {30'd0, rsp_word}, 64'd0);
    check("rst_adr_dat", {wb_adr, wb_dat_o}, 64'd0);

    prev_addr = 32'h0;
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i], word, lat, stb_cnt, bus_adr, bus_we, bus_dat, bus_sel, busy_ok);
      check($sformatf("v%0d_rsp", i), {30'd0, word}, {30'd0, vecs[i].exp_code, vecs[i].exp_pay});
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_stb_cycles", i), 64'(stb_cnt), 64'(vecs[i].exp_stb));
      check($sformatf("v%0d_addr", i), {32'd0, wb_adr}, {32'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_busy", i), {63'd0, busy_ok}, 64'd1);
      if (vecs[i].exp_stb > 0) begin
        check($sformatf("v%0d_bus_adr", i), {32'd0, bus_adr}, {32'd0, prev_addr});
        check($sformatf("v%0d_bus_we_sel", i), {59'd0, bus_we, bus_sel},
              {59'd0, vecs[i].op == OP_WR, 4'hF});
        if (vecs[i].op == OP_WR)
          check($sformatf("v%0d_bus_dat", i), {32'd0, bus_dat}, {32'd0, vecs[i].payload});
      end
      prev_addr = vecs[i].exp_addr;
      tick();
      check($sformatf("v%0d_idle", i), {62'd0, wb_stb, wb_sel != 4'h0}, 64'd0);
    end

    // Command held during BUS is ignored; a command in the RESP cycle is accepted.
    base = rsp_count;
    cmd_stb = 1'b1; cmd_word = {OP_WR, 32'h00000011};
    tick();
    cmd_word = {OP_SET, 32'h00007777};
    tick();
    wb_ack = 1'b1; cmd_stb = 1'b0;
    tick();
    wb_ack = 1'b0;
    check("busy_rsp_stb", {63'd0, rsp_stb}, 64'd1);
    check("busy_rsp_word", {30'd0, rsp_word}, {30'd0, R_WR, 32'h00000000});
    check("busy_addr", {32'd0, wb_adr}, 64'h4);
    cmd_stb = 1'b1; cmd_word = {OP_SET, 32'h00000500};
    tick();
    cmd_stb = 1'b0;
    check("resp_accept", {29'd0, rsp_stb, rsp_word}, {29'd0, 1'b1, R_ADDR, 32'h00000500});
    tick(); tick();
    check("rsp_count", 64'(rsp_count - base), 64'd2);

    // Reset in the middle of a bus cycle.
    base = rsp_count;
    cmd_stb = 1'b1; cmd_word = {OP_RD, 32'h0};
    tick();
    cmd_stb = 1'b0;
    tick();
    check("pre_rst_cyc", {63'd0, wb_cyc}, 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_cyc", {62'd0, wb_cyc, wb_stb}, 64'd0);
    check("mid_rst_addr", {32'd0, wb_adr}, 64'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("mid_rst_no_rsp", 64'(rsp_count - base), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
